// File: rtl/approx_err_pkg.sv
// Shared types and helpers for the approximate-adder error monitor.
// Holds the run-state enum, default widths and the saturating-add helper.
package approx_err_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int DEF_WIDTH       = 16;
  localparam int DEF_APPROX_BITS = 10;
  localparam int DEF_CNT_W       = 16;
  localparam int DEF_ACC_W       = 40;

  // Widest accumulator sat_add can serve; the squared-error sum at ACC_W=40 fits exactly.
  localparam int SAT_W = 64;

  function automatic logic [SAT_W-1:0] sat_add(input logic [SAT_W-1:0] a,
                                               input logic [SAT_W-1:0] b,
                                               input int               w);
    logic [SAT_W:0] sum;
    logic [SAT_W:0] lim;
    logic [SAT_W:0] one;
    one = {{SAT_W{1'b0}}, 1'b1};
    sum = {1'b0, a} + {1'b0, b};
    lim = (w >= SAT_W) ? {1'b0, {SAT_W{1'b1}}} : ((one << w) - one);
    return (sum > lim) ? lim[SAT_W-1:0] : sum[SAT_W-1:0];
  endfunction

endpackage

// File: rtl/err_abs_diff.sv
// Stage-1 logic of the error monitor: exact sum of the operands and the
// magnitude of its difference from the approximate adder's output.
module err_abs_diff
  import approx_err_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [WIDTH:0]   approx_sum,
  output logic [WIDTH:0]   exact_sum,
  output logic [WIDTH:0]   abs_diff
);

  logic signed [WIDTH+1:0] diff;
  logic        [WIDTH+1:0] neg_diff;

  // The extra sign bit keeps exact - approx exact for every pair; |diff| fits in WIDTH+1 bits.
  always_comb begin
    exact_sum = {1'b0, in1} + {1'b0, in2};
    diff      = $signed({1'b0, exact_sum}) - $signed({1'b0, approx_sum});
    neg_diff  = -diff;
    abs_diff  = diff[WIDTH+1] ? neg_diff[WIDTH:0] : diff[WIDTH:0];
  end

endmodule

// File: rtl/approx_add_err_monitor.sv
// Error monitor for approximate ripple-carry adders: accumulates |exact - approx| over a run.
// Define APPROX_ERR_MSE_EN to add the saturating squared-error sum and its sq_sum port.
module approx_add_err_monitor
  import approx_err_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int APPROX_BITS = DEF_APPROX_BITS,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int ACC_W       = DEF_ACC_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] num_samples,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] IN1,
  input  logic [WIDTH-1:0] IN2,
  input  logic [WIDTH:0]   approx_sum,
  output logic             busy,
  output logic             done,
  output logic [ACC_W-1:0] err_sum,
  output logic [WIDTH:0]   err_max,
  output logic [CNT_W-1:0] err_cnt
`ifdef APPROX_ERR_MSE_EN
  ,
  output logic [ACC_W+23:0] sq_sum
`endif
);

  // APPROX_BITS only documents which adder variant is being characterised.
  if (APPROX_BITS > WIDTH) begin : g_approx_bits_exceed_width
  end

  state_t           state_q, state_d;
  logic [CNT_W-1:0] num_q;
  logic [CNT_W-1:0] acc_cnt;
  logic             s1_valid;
  logic [WIDTH:0]   s1_diff;
  logic [WIDTH:0]   exact_sum;
  logic [WIDTH:0]   abs_diff;
  logic [SAT_W-1:0] sum_sat;
  logic             take_start;
  logic             fire;

  err_abs_diff #(.WIDTH(WIDTH)) u_abs_diff (
    .in1        (IN1),
    .in2        (IN2),
    .approx_sum (approx_sum),
    .exact_sum  (exact_sum),
    .abs_diff   (abs_diff)
  );

  assign take_start = start && (state_q == IDLE || state_q == DONE);
  assign fire       = in_valid && in_ready;

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignment so every register samples pre-edge values.
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    // NOTE: default first so no branch leaves state_d unassigned and infers a latch.
    state_d = state_q;
    unique case (state_q)
      IDLE, DONE: if (start) state_d = (num_samples == '0) ? DONE : RUN;
      RUN:        if (acc_cnt == num_q) state_d = DRAIN;
      DRAIN:      if (!s1_valid) state_d = DONE;
      default:    state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state_q == RUN) && (acc_cnt < num_q);
    busy     = (state_q == RUN) || (state_q == DRAIN);
    done     = (state_q == DONE);
  end

  always_comb sum_sat = sat_add(SAT_W'(err_sum), SAT_W'(s1_diff), ACC_W);

  always_ff @(posedge clk) begin
    if (rst || take_start) begin
      num_q    <= rst ? '0 : num_samples;
      acc_cnt  <= '0;
      s1_valid <= 1'b0;
      s1_diff  <= '0;
      err_sum  <= '0;
      err_max  <= '0;
      err_cnt  <= '0;
    end else begin
      s1_valid <= fire;
      if (fire) begin
        s1_diff <= abs_diff;
        acc_cnt <= acc_cnt + 1'b1;
      end
      if (s1_valid) begin
        err_sum <= sum_sat[ACC_W-1:0];
        if (s1_diff > err_max) err_max <= s1_diff;
        err_cnt <= err_cnt + {{(CNT_W-1){1'b0}}, (s1_diff != '0)};
      end
    end
  end

`ifdef APPROX_ERR_MSE_EN
  logic [2*WIDTH+1:0] sq_diff;
  logic [SAT_W-1:0]   sq_sat;

  always_comb begin
    sq_diff = s1_diff * s1_diff;
    sq_sat  = sat_add(SAT_W'(sq_sum), SAT_W'(sq_diff), ACC_W + 24);
  end

  always_ff @(posedge clk) begin
    if (rst || take_start) sq_sum <= '0;
    else if (s1_valid)     sq_sum <= sq_sat[ACC_W+23:0];
  end
`endif

endmodule

// File: tb/tb_approx_add_err_monitor.sv
// Scoreboard bench for approx_add_err_monitor: a default instance and a narrow
// (ACC_W=12) instance share stimulus; honours APPROX_ERR_MSE_EN for sq_sum.
module tb_approx_add_err_monitor;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] num_samples = '0;
  logic        in_valid = 1'b0;
  logic [15:0] in1 = '0, in2 = '0;
  logic [16:0] approx_sum = '0;

  logic        in_ready, busy, done;
  logic [39:0] err_sum;
  logic [16:0] err_max;
  logic [15:0] err_cnt;
  logic        in_ready_s, busy_s, done_s;
  logic [11:0] err_sum_s;
  logic [16:0] err_max_s;
  logic [15:0] err_cnt_s;
`ifdef APPROX_ERR_MSE_EN
  logic [63:0] sq_sum;
  logic [35:0] sq_sum_s;
`endif

  approx_add_err_monitor u_dut (
    .clk(clk), .rst(rst), .start(start), .num_samples(num_samples),
    .in_valid(in_valid), .in_ready(in_ready), .IN1(in1), .IN2(in2),
    .approx_sum(approx_sum), .busy(busy), .done(done),
    .err_sum(err_sum), .err_max(err_max), .err_cnt(err_cnt)
`ifdef APPROX_ERR_MSE_EN
    , .sq_sum(sq_sum)
`endif
  );

  approx_add_err_monitor #(.ACC_W(12)) u_small (
    .clk(clk), .rst(rst), .start(start), .num_samples(num_samples),
    .in_valid(in_valid), .in_ready(in_ready_s), .IN1(in1), .IN2(in2),
    .approx_sum(approx_sum), .busy(busy_s), .done(done_s),
    .err_sum(err_sum_s), .err_max(err_max_s), .err_cnt(err_cnt_s)
`ifdef APPROX_ERR_MSE_EN
    , .sq_sum(sq_sum_s)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    longint sum;
    longint sum_small;
    longint max;
    longint cnt;
    longint sq;
    longint lat;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;
  int   pops  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: on each result presentation pop the expected record and compare.
  initial begin : monitor
    logic done_q, start_prev;
    int   last_evt;
    exp_t e;
    done_q = 1'b0; start_prev = 1'b0; last_evt = 0;
    forever begin
      @(negedge clk);
      if (done && (!done_q || start_prev)) begin
        if (sb_q.size() == 0) begin
          check("unexpected_done", 64'd1, 64'd0);
        end else begin
          e = sb_q.pop_front();
          check("err_sum",       64'(err_sum),   64'(e.sum));
          check("err_max",       64'(err_max),   64'(e.max));
          check("err_cnt",       64'(err_cnt),   64'(e.cnt));
          check("latency",       64'(cyc - last_evt), 64'(e.lat));
          check("small_done",    64'(done_s),    64'd1);
          check("small_err_sum", 64'(err_sum_s), 64'(e.sum_small));
          check("small_err_max", 64'(err_max_s), 64'(e.max));
          check("small_err_cnt", 64'(err_cnt_s), 64'(e.cnt));
`ifdef APPROX_ERR_MSE_EN
          check("sq_sum",        sq_sum,         64'(e.sq));
          check("small_sq_sum",  64'(sq_sum_s),  64'(e.sq));
`endif
        end
        pops++;
      end
      if (in_valid && in_ready) last_evt = cyc;
      if (start && !busy) last_evt = cyc;
      start_prev = start && !busy;
      done_q     = done;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_start(input logic [15:0] n);
    num_samples = n;
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic [16:0] s);
    logic hs;
    int   t;
    hs = 1'b0; t = 0;
    in_valid = 1'b1; in1 = a; in2 = b; approx_sum = s;
    while (!hs && t < 20) begin
      @(negedge clk);
      hs = in_ready;
      tick(1);
      t++;
    end
    if (!hs) check("send_timeout", 64'd0, 64'd1);
    in_valid = 1'b0;
  endtask

  task automatic wait_pops(input int target);
    int t;
    t = 0;
    while (pops < target && t < 50) begin tick(1); t++; end
    if (pops < target) check("done_timeout", 64'(pops), 64'(target));
  endtask

  task automatic push(input longint s, input longint ss, input longint m,
                      input longint c, input longint q, input longint l);
    exp_t e;
    e.sum = s; e.sum_small = ss; e.max = m; e.cnt = c; e.sq = q; e.lat = l;
    sb_q.push_back(e);
  endtask

  task automatic send_basic4(input bit gaps);
    send(16'h0000, 16'h0000, 17'h00400);
    if (gaps) begin in1 = 16'hFFFF; in2 = 16'h0000; approx_sum = 17'h0; tick(1); end
    send(16'h03FF, 16'h0001, 17'h00400);
    if (gaps) begin in1 = 16'hFFFF; in2 = 16'h0000; approx_sum = 17'h0; tick(1); end
    send(16'hFFFF, 16'hFFFF, 17'h1FC00);
    if (gaps) begin in1 = 16'hFFFF; in2 = 16'h0000; approx_sum = 17'h0; tick(1); end
    send(16'h0200, 16'h0200, 17'h00400);
  endtask

  // diffs 1024, 0, 1022, 0: sum 2046, max 1024, two nonzero, squares 1048576 + 1044484
  localparam longint BASIC_SQ = 64'd2093060;

  initial begin
    tick(3);
    rst = 1'b0;
    tick(10);
    @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_busy",     64'(busy),     64'd0);
    check("rst_done",     64'(done),     64'd0);
    check("rst_err_sum",  64'(err_sum),  64'd0);
    check("rst_err_max",  64'(err_max),  64'd0);
    check("rst_err_cnt",  64'(err_cnt),  64'd0);
`ifdef APPROX_ERR_MSE_EN
    check("rst_sq_sum",   sq_sum,        64'd0);
`endif
    tick(1);

    // back-to-back basic run
    push(2046, 2046, 1024, 2, BASIC_SQ, 3);
    do_start(16'd4);
    send_basic4(1'b0);
    wait_pops(1);
    tick(3);
    @(negedge clk);
    check("hold_err_sum",  64'(err_sum),  64'd2046);
    check("hold_in_ready", 64'(in_ready), 64'd0);
    tick(1);

    // same samples with idle gaps carrying junk operands
    push(2046, 2046, 1024, 2, BASIC_SQ, 3);
    do_start(16'd4);
    send_basic4(1'b1);
    wait_pops(2);
    tick(2);

    // zero-length run from DONE: results cleared, in_ready never raised
    push(0, 0, 0, 0, 0, 1);
    do_start(16'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("zero_in_ready", 64'(in_ready), 64'd0);
      tick(1);
    end
    wait_pops(3);

    // start pulse in the middle of a run is ignored
    push(2046, 2046, 1024, 2, BASIC_SQ, 3);
    do_start(16'd4);
    send(16'h0000, 16'h0000, 17'h00400);
    send(16'h03FF, 16'h0001, 17'h00400);
    do_start(16'd1);
    num_samples = 16'd0;
    send(16'hFFFF, 16'hFFFF, 17'h1FC00);
    send(16'h0200, 16'h0200, 17'h00400);
    wait_pops(4);
    tick(2);

    // accumulator saturation in the narrow instance
    push(5120, 4095, 1024, 5, 5 * 1048576, 3);
    do_start(16'd5);
    repeat (5) send(16'h0000, 16'h0000, 17'h00400);
    wait_pops(5);
    tick(2);

    // single sample
    push(1024, 1024, 1024, 1, 1048576, 3);
    do_start(16'd1);
    send(16'h0000, 16'h0000, 17'h00400);
    wait_pops(6);
    tick(2);

    // reset in the middle of a run aborts and clears
    do_start(16'd4);
    send(16'h0000, 16'h0000, 17'h00400);
    send(16'h0000, 16'h0000, 17'h00400);
    tick(1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    @(negedge clk);
    check("abort_busy",     64'(busy),     64'd0);
    check("abort_in_ready", 64'(in_ready), 64'd0);
    check("abort_done",     64'(done),     64'd0);
    check("abort_err_sum",  64'(err_sum),  64'd0);
    check("abort_err_max",  64'(err_max),  64'd0);
    check("abort_err_cnt",  64'(err_cnt),  64'd0);
`ifdef APPROX_ERR_MSE_EN
    check("abort_sq_sum",   sq_sum,        64'd0);
`endif
    tick(1);

    // fresh run from IDLE after the abort
    push(1024, 1024, 1024, 1, 1048576, 3);
    do_start(16'd1);
    send(16'h0000, 16'h0000, 17'h00400);
    wait_pops(7);
    tick(2);

    check("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
